// File: rtl/serial_sample_receiver.sv
// Deserialises a framed, MSB-first serial stream into words for the sample memory.
// Writes go to a wrapping circular pointer. Framing errors and the first wrap are flagged.
module serial_sample_receiver #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  Sclk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  Clear,
    input  logic                  Frame,
    input  logic                  Serial_in,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] Write_Address,
    output logic                  write_enable,
    output logic                  input_ready,
    output logic                  frame_error,
    output logic                  wrapped
);

    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CntLoad = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CntLsb  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntDone = '0;

    logic [0:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  wrap_q, wrap_d;

    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] msb_only;
    logic                  err_event;
    logic                  wrap_event;

    assign shift_next = {shift_q[DATA_WIDTH-2:0], Serial_in};
    assign msb_only   = {{(DATA_WIDTH-1){1'b0}}, Serial_in};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        err_event  = 1'b0;
        wrap_event = 1'b0;

        if (!Start) begin
            // Receive disabled: any partial word is dropped silently.
            state_d = StIdle;
            cnt_d   = CntDone;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Frame) begin
                        state_d = StShift;
                        shift_d = msb_only;
                        cnt_d   = CntLoad;
                    end
                end
                StShift: begin
                    if (cnt_q == CntDone) begin
                        // Word just completed: Frame here starts the next word with no gap.
                        if (Frame) begin
                            shift_d = msb_only;
                            cnt_d   = CntLoad;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (Frame && (cnt_q != CntLsb)) begin
                        err_event = 1'b1;
                        shift_d   = msb_only;
                        cnt_d     = CntLoad;
                    end else begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q - CntLsb;
                        if (cnt_q == CntLsb) begin
                            data_d     = shift_next;
                            addr_d     = ptr_q;
                            we_d       = 1'b1;
                            ptr_d      = ptr_q + ADDR_WIDTH'(1);
                            wrap_event = (ptr_q == '1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = CntDone;
                end
            endcase
        end

        // Clear beats the increment, but a fresh event beats the clear of its flag.
        if (Clear) begin
            ptr_d = '0;
        end
        err_d  = err_event  | (err_q  & ~Clear);
        wrap_d = wrap_event | (wrap_q & ~Clear);
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data_in       = data_q;
    assign Write_Address = addr_q;
    assign write_enable  = we_q;
    assign input_ready   = we_q;
    assign frame_error   = err_q;
    assign wrapped       = wrap_q;

endmodule

// File: tb/tb_serial_sample_receiver.sv
// Bench for serial_sample_receiver: directed scenarios plus random traffic, every cycle
// compared against a bit-queue model of the framing rules.
module tb_serial_sample_receiver;

    logic        Sclk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Clear;
    logic        Frame;
    logic        Serial_in;
    logic [15:0] data_in;
    logic [7:0]  Write_Address;
    logic        write_enable;
    logic        input_ready;
    logic        frame_error;
    logic        wrapped;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          bits[$];
    int          m_ptr;
    logic [15:0] m_data;
    logic [7:0]  m_addr;
    logic        m_we;
    logic        m_err;
    logic        m_wrap;

    always #5 Sclk = ~Sclk;

    serial_sample_receiver #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8)
    ) dut (
        .Sclk         (Sclk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Clear        (Clear),
        .Frame        (Frame),
        .Serial_in    (Serial_in),
        .data_in      (data_in),
        .Write_Address(Write_Address),
        .write_enable (write_enable),
        .input_ready  (input_ready),
        .frame_error  (frame_error),
        .wrapped      (wrapped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        m_ptr  = 0;
        m_data = '0;
        m_addr = '0;
        m_we   = 1'b0;
        m_err  = 1'b0;
        m_wrap = 1'b0;
    endtask

    // One clock edge of the framing rules, expressed on a queue of received bits.
    task automatic model_step(input bit start, input bit frame, input bit sin, input bit clear);
        bit ev_err;
        bit ev_wrap;
        int w;
        ev_err  = 1'b0;
        ev_wrap = 1'b0;
        m_we    = 1'b0;
        if (!start) begin
            bits.delete();
        end else if (bits.size() == 0) begin
            if (frame) bits.push_back(sin);
        end else if (frame && bits.size() < 15) begin
            ev_err = 1'b1;
            bits.delete();
            bits.push_back(sin);
        end else begin
            bits.push_back(sin);
            if (bits.size() == 16) begin
                w = 0;
                foreach (bits[i]) w = w * 2 + int'(bits[i]);
                m_data = w[15:0];
                m_addr = m_ptr[7:0];
                m_we   = 1'b1;
                if (m_ptr == 255) ev_wrap = 1'b1;
                m_ptr = (m_ptr + 1) % 256;
                bits.delete();
            end
        end
        if (clear) m_ptr = 0;
        m_err  = ev_err  || (m_err  && !clear);
        m_wrap = ev_wrap || (m_wrap && !clear);
    endtask

    task automatic check_all();
        check("write_enable", write_enable, m_we);
        check("input_ready", input_ready, m_we);
        check("data_in", data_in, m_data);
        check("Write_Address", Write_Address, m_addr);
        check("frame_error", frame_error, m_err);
        check("wrapped", wrapped, m_wrap);
    endtask

    task automatic tick(input bit start, input bit frame, input bit sin, input bit clear);
        Start     = start;
        Frame     = frame;
        Serial_in = sin;
        Clear     = clear;
        @(posedge Sclk);
        #1;
        model_step(start, frame, sin, clear);
        check_all();
    endtask

    task automatic send_word(input logic [15:0] w, input bit clr_last);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, i == 0, w[15-i], clr_last && (i == 15));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
    endtask

    initial begin
        Reset_n   = 1'b0;
        Start     = 1'b0;
        Clear     = 1'b0;
        Frame     = 1'b0;
        Serial_in = 1'b0;
        model_reset();
        #12;
        check_all();
        Reset_n = 1'b1;

        // Single frame
        idle(2);
        send_word(16'hA5C3, 1'b0);
        check("t1_strobe", write_enable, 1'b1);
        check("t1_data", data_in, 16'hA5C3);
        check("t1_addr", Write_Address, 8'd0);
        idle(1);
        check("t1_single", write_enable, 1'b0);
        idle(2);

        // Back-to-back frames
        send_word(16'h0001, 1'b0);
        send_word(16'h8000, 1'b0);
        send_word(16'hFFFF, 1'b0);
        check("b2b_addr", Write_Address, 8'd3);
        idle(3);

        // Frame re-asserted at bit 7
        for (int i = 0; i < 7; i++) tick(1'b1, i == 0, $urandom_range(0, 1) == 1, 1'b0);
        send_word(16'h1234, 1'b0);
        check("ferr_set", frame_error, 1'b1);
        check("ferr_data", data_in, 16'h1234);
        check("ferr_addr", Write_Address, 8'd4);
        idle(2);

        // Clear, then wrap the pointer
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_ferr", frame_error, 1'b0);
        for (int n = 0; n < 256; n++) send_word(16'h0000, 1'b0);
        check("wrap_addr", Write_Address, 8'd255);
        check("wrap_set", wrapped, 1'b1);
        send_word(16'h0000, 1'b0);
        check("wrap_257", Write_Address, 8'd0);
        idle(1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_wrap", wrapped, 1'b0);

        // Start dropped mid-word
        send_word(16'h5555, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, i == 0, $urandom_range(0, 1) == 1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_word(16'h7E7E, 1'b0);
        check("drop_addr", Write_Address, 8'd1);
        check("drop_ferr", frame_error, 1'b0);
        idle(1);

        // Clear coincident with a strobe
        send_word(16'($urandom), 1'b1);
        send_word(16'($urandom), 1'b0);
        check("clr_strobe_addr", Write_Address, 8'd0);
        idle(2);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) tick(1'b1, i == 0, 1'b1, 1'b0);
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        Reset_n = 1'b1;
        send_word(16'h00FF, 1'b0);
        check("rst_addr", Write_Address, 8'd0);
        check("rst_data", data_in, 16'h00FF);
        idle(2);

        // Random well-formed frames with random gaps
        for (int n = 0; n < 40; n++) begin
            send_word(16'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Fully random control traffic
        for (int n = 0; n < 1500; n++) begin
            tick($urandom_range(0, 29) != 0, $urandom_range(0, 13) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 79) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
